// File: rtl/i2c_avalon_csr.sv
// Avalon-MM register front-end for the I2C byte engine: command FIFO, RX FIFO, status/sticky flags, SCL divider.
// Define I2C_IRQ_EN to add the registered irq output and the CTRL[2] irq_en bit.

module i2c_avalon_csr #(
    parameter int          CMD_DEPTH    = 8,
    parameter int          RX_DEPTH     = 8,
    parameter logic [31:0] CLKDIV_RESET = 32'd249
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [31:0] clk_div,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_data,
    output logic        cmd_start,
    output logic        cmd_stop,
    output logic        cmd_read,
    output logic        cmd_nack,
    input  logic        rsp_valid,
    input  logic        rsp_is_read,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    input  logic        core_busy
`ifdef I2C_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    localparam logic [CAW:0]   CMD_FULL_LVL = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW:0]   RX_FULL_LVL  = (RAW+1)'(RX_DEPTH);
    localparam logic [CAW:0]   CMD_CNT_ONE  = (CAW+1)'(1);
    localparam logic [RAW:0]   RX_CNT_ONE   = (RAW+1)'(1);
    localparam logic [CAW-1:0] CMD_PTR_ONE  = CAW'(1);
    localparam logic [RAW-1:0] RX_PTR_ONE   = RAW'(1);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_CLKDIV = 3'd1;
    localparam logic [2:0] ADDR_CMD    = 3'd2;
    localparam logic [2:0] ADDR_RXDATA = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    logic [11:0]    cmd_mem_r [CMD_DEPTH];
    logic [CAW-1:0] cmd_wr_ptr_r;
    logic [CAW-1:0] cmd_rd_ptr_r;
    logic [CAW:0]   cmd_cnt_r;
    logic [7:0]     rx_mem_r [RX_DEPTH];
    logic [RAW-1:0] rx_wr_ptr_r;
    logic [RAW-1:0] rx_rd_ptr_r;
    logic [RAW:0]   rx_cnt_r;

    logic        enable_r;
    logic [31:0] clk_div_r;
    logic        cmd_ovf_r;
    logic        rx_ovf_r;
    logic        nack_err_r;
    logic [31:0] readdata_r;

    logic        wr_ctrl_s;
    logic        wr_clkdiv_s;
    logic        wr_cmd_s;
    logic        wr_status_s;
    logic        rd_rxdata_s;
    logic        flush_s;
    logic        cmd_full_s;
    logic        cmd_empty_s;
    logic        rx_full_s;
    logic        rx_empty_s;
    logic        cmd_valid_s;
    logic        cmd_push_s;
    logic        cmd_pop_s;
    logic        cmd_ovf_set_s;
    logic        rx_push_req_s;
    logic        rx_push_s;
    logic        rx_pop_s;
    logic        rx_ovf_set_s;
    logic        nack_set_s;
    logic        irq_en_s;
    logic [11:0] cmd_head_s;
    logic [7:0]  rx_head_s;
    logic [7:0]  cmd_lvl_s;
    logic [7:0]  rx_lvl_s;
    logic [31:0] status_s;
    logic [31:0] rdata_s;

    assign wr_ctrl_s   = avs_write & (avs_address == ADDR_CTRL);
    assign wr_clkdiv_s = avs_write & (avs_address == ADDR_CLKDIV);
    assign wr_cmd_s    = avs_write & (avs_address == ADDR_CMD);
    assign wr_status_s = avs_write & (avs_address == ADDR_STATUS);
    assign rd_rxdata_s = avs_read  & (avs_address == ADDR_RXDATA);
    assign flush_s     = wr_ctrl_s & avs_writedata[1];

    assign cmd_full_s  = (cmd_cnt_r == CMD_FULL_LVL);
    assign cmd_empty_s = (cmd_cnt_r == '0);
    assign rx_full_s   = (rx_cnt_r == RX_FULL_LVL);
    assign rx_empty_s  = (rx_cnt_r == '0);

    // Fullness is judged at cycle start, so a same-cycle pop never rescues a push into a full queue
    assign cmd_valid_s   = enable_r & ~cmd_empty_s;
    assign cmd_pop_s     = cmd_valid_s & cmd_ready;
    assign cmd_push_s    = wr_cmd_s & ~cmd_full_s;
    assign cmd_ovf_set_s = wr_cmd_s & cmd_full_s;

    assign rx_push_req_s = rsp_valid & rsp_is_read;
    assign rx_push_s     = rx_push_req_s & ~rx_full_s;
    assign rx_ovf_set_s  = rx_push_req_s & rx_full_s;
    assign rx_pop_s      = rd_rxdata_s & ~rx_empty_s;
    assign nack_set_s    = rsp_valid & ~rsp_is_read & rsp_nack;

    assign cmd_head_s = cmd_mem_r[cmd_rd_ptr_r];
    assign rx_head_s  = rx_mem_r[rx_rd_ptr_r];
    assign cmd_lvl_s  = 8'(cmd_cnt_r);
    assign rx_lvl_s   = 8'(rx_cnt_r);

    assign cmd_valid    = cmd_valid_s;
    assign cmd_data     = cmd_head_s[7:0];
    assign cmd_start    = cmd_head_s[8];
    assign cmd_stop     = cmd_head_s[9];
    assign cmd_read     = cmd_head_s[10];
    assign cmd_nack     = cmd_head_s[11];
    assign clk_div      = clk_div_r;
    assign avs_readdata = readdata_r;

    assign status_s = {8'd0, rx_lvl_s, cmd_lvl_s, nack_err_r, rx_ovf_r, cmd_ovf_r,
                       rx_full_s, rx_empty_s, cmd_empty_s, cmd_full_s, core_busy};

    // Command FIFO storage (data path, no reset needed)
    always_ff @(posedge clk) begin
        if (cmd_push_s) begin
            cmd_mem_r[cmd_wr_ptr_r] <= avs_writedata[11:0];
        end
    end

    // Command FIFO pointers and occupancy; flush overrides any push/pop
    always_ff @(posedge clk) begin
        if (!reset_n || flush_s) begin
            cmd_wr_ptr_r <= '0;
            cmd_rd_ptr_r <= '0;
            cmd_cnt_r    <= '0;
        end else begin
            if (cmd_push_s) begin
                cmd_wr_ptr_r <= cmd_wr_ptr_r + CMD_PTR_ONE;
            end
            if (cmd_pop_s) begin
                cmd_rd_ptr_r <= cmd_rd_ptr_r + CMD_PTR_ONE;
            end
            case ({cmd_push_s, cmd_pop_s})
                2'b10:   cmd_cnt_r <= cmd_cnt_r + CMD_CNT_ONE;
                2'b01:   cmd_cnt_r <= cmd_cnt_r - CMD_CNT_ONE;
                default: cmd_cnt_r <= cmd_cnt_r;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= rsp_data;
        end
    end

    // RX FIFO pointers and occupancy; flush overrides any push/pop
    always_ff @(posedge clk) begin
        if (!reset_n || flush_s) begin
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
            rx_cnt_r    <= '0;
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + RX_PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + RX_PTR_ONE;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_cnt_r <= rx_cnt_r + RX_CNT_ONE;
                2'b01:   rx_cnt_r <= rx_cnt_r - RX_CNT_ONE;
                default: rx_cnt_r <= rx_cnt_r;
            endcase
        end
    end

    // CTRL enable bit and CLKDIV register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable_r  <= 1'b0;
            clk_div_r <= CLKDIV_RESET;
        end else begin
            if (wr_ctrl_s) begin
                enable_r <= avs_writedata[0];
            end
            if (wr_clkdiv_s) begin
                clk_div_r <= avs_writedata;
            end
        end
    end

    // Sticky error flags: a set event beats a same-cycle W1C
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_ovf_r  <= 1'b0;
            rx_ovf_r   <= 1'b0;
            nack_err_r <= 1'b0;
        end else begin
            cmd_ovf_r  <= cmd_ovf_set_s | (cmd_ovf_r  & ~(wr_status_s & avs_writedata[5]));
            rx_ovf_r   <= rx_ovf_set_s  | (rx_ovf_r   & ~(wr_status_s & avs_writedata[6]));
            nack_err_r <= nack_set_s    | (nack_err_r & ~(wr_status_s & avs_writedata[7]));
        end
    end

`ifdef I2C_IRQ_EN
    logic irq_en_r;
    logic irq_r;

    assign irq_en_s = irq_en_r;
    assign irq      = irq_r;

    // Interrupt enable and registered interrupt request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                irq_en_r <= avs_writedata[2];
            end
            irq_r <= irq_en_r & ((cmd_empty_s & ~core_busy) | ~rx_empty_s |
                                 cmd_ovf_r | rx_ovf_r | nack_err_r);
        end
    end
`else
    assign irq_en_s = 1'b0;
`endif

    // Read-data multiplexer; flush bit always reads back as 0
    always_comb begin
        rdata_s = 32'd0;
        case (avs_address)
            ADDR_CTRL:   rdata_s = {29'd0, irq_en_s, 1'b0, enable_r};
            ADDR_CLKDIV: rdata_s = clk_div_r;
            ADDR_RXDATA: begin
                if (!rx_empty_s) begin
                    rdata_s = {22'd0, 1'b0, 1'b1, rx_head_s};
                end else begin
                    rdata_s = 32'd0;
                end
            end
            ADDR_STATUS: rdata_s = status_s;
            default:     rdata_s = 32'd0;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else if (avs_read) begin
            readdata_r <= rdata_s;
        end
    end

endmodule

// File: tb/tb_i2c_avalon_csr.sv
// Self-checking bench for i2c_avalon_csr: register vector table, directed corner sequences, random run vs queue model.
module tb_i2c_avalon_csr;

    localparam int CMD_DEPTH = 8;
    localparam int RX_DEPTH  = 8;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_CLKDIV = 3'd1;
    localparam logic [2:0] A_CMD    = 3'd2;
    localparam logic [2:0] A_RXDATA = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

`ifdef I2C_IRQ_EN
    localparam logic [31:0] CTRL_IRQ_BIT = 32'h4;
`else
    localparam logic [31:0] CTRL_IRQ_BIT = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [31:0] clk_div;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_data;
    logic        cmd_start;
    logic        cmd_stop;
    logic        cmd_read;
    logic        cmd_nack;
    logic        rsp_valid;
    logic        rsp_is_read;
    logic [7:0]  rsp_data;
    logic        rsp_nack;
    logic        core_busy;
`ifdef I2C_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_avalon_csr #(.CMD_DEPTH(CMD_DEPTH), .RX_DEPTH(RX_DEPTH), .CLKDIV_RESET(32'd249)) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .clk_div(clk_div),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid), .rsp_is_read(rsp_is_read), .rsp_data(rsp_data),
        .rsp_nack(rsp_nack), .core_busy(core_busy)
`ifdef I2C_IRQ_EN
        , .irq(irq)
`endif
    );

    typedef struct packed {
        logic        is_wr;
        logic        busy;
        logic [2:0]  addr;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    // behavioural reference state for the random phase
    logic [11:0] mcq [$];
    logic [7:0]  mrq [$];
    logic        men, mien, movf_c, movf_r, mnack, mirq;
    logic [31:0] mdiv, mrd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        avs_address = 3'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_is_read = 1'b0; rsp_data = 8'd0;
        rsp_nack = 1'b0; core_busy = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        idle_inputs();
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic rd_chk(input string n, input logic [2:0] a, input logic [31:0] e);
        logic [31:0] d;
        rd(a, d);
        chk(n, d, e);
    endtask

    task automatic rsp_push(input logic [7:0] d);
        rsp_valid = 1'b1; rsp_is_read = 1'b1; rsp_data = d;
        tick();
        rsp_valid = 1'b0; rsp_is_read = 1'b0;
    endtask

    task automatic model_reset();
        mcq.delete(); mrq.delete();
        men = 1'b0; mien = 1'b0; movf_c = 1'b0; movf_r = 1'b0; mnack = 1'b0; mirq = 1'b0;
        mdiv = 32'd249; mrd = 32'd0;
    endtask

    // advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic        cfull, rfull, cval, flush, pop_r, push_c;
        logic [31:0] st, wd;
        wd    = avs_writedata;
        cfull = (mcq.size() == CMD_DEPTH);
        rfull = (mrq.size() == RX_DEPTH);
        cval  = men && (mcq.size() != 0);
        flush = 1'b0; pop_r = 1'b0; push_c = 1'b0;
        st = {8'd0, 8'(mrq.size()), 8'(mcq.size()), mnack, movf_r, movf_c, rfull,
              (mrq.size() == 0), (mcq.size() == 0), cfull, core_busy};
        mirq = mien && ((mcq.size() == 0 && !core_busy) || mrq.size() != 0 || movf_c || movf_r || mnack);
        if (avs_read) begin
            case (avs_address)
                A_CTRL:   mrd = {29'd0, mien, 1'b0, men};
                A_CLKDIV: mrd = mdiv;
                A_RXDATA: begin
                    if (mrq.size() != 0) begin
                        mrd = {23'd0, 1'b1, mrq[0]};
                        pop_r = 1'b1;
                    end else begin
                        mrd = 32'd0;
                    end
                end
                A_STATUS: mrd = st;
                default:  mrd = 32'd0;
            endcase
        end
        if (cval && cmd_ready) void'(mcq.pop_front());
        if (pop_r) void'(mrq.pop_front());
        if (avs_write) begin
            case (avs_address)
                A_CTRL: begin
                    men   = wd[0];
                    flush = wd[1];
`ifdef I2C_IRQ_EN
                    mien  = wd[2];
`endif
                end
                A_CLKDIV: mdiv = wd;
                A_CMD:    begin if (cfull) push_c = 1'b0; else push_c = 1'b1; end
                A_STATUS: begin
                    movf_c = movf_c & ~wd[5];
                    movf_r = movf_r & ~wd[6];
                    mnack  = mnack  & ~wd[7];
                end
                default: ;
            endcase
            if (avs_address == A_CMD && cfull) movf_c = 1'b1;
        end
        if (push_c) mcq.push_back(wd[11:0]);
        if (rsp_valid && rsp_is_read) begin
            if (rfull) movf_r = 1'b1;
            else mrq.push_back(rsp_data);
        end
        if (rsp_valid && !rsp_is_read && rsp_nack) mnack = 1'b1;
        if (flush) begin
            mcq.delete();
            mrq.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        vt[0]  = '{1'b0, 1'b0, A_CLKDIV, 32'd249};
        vt[1]  = '{1'b0, 1'b0, A_STATUS, 32'h0000_000C};
        vt[2]  = '{1'b0, 1'b0, A_CTRL,   32'd0};
        vt[3]  = '{1'b0, 1'b1, A_STATUS, 32'h0000_000D};
        vt[4]  = '{1'b1, 1'b0, A_CLKDIV, 32'h1234_5678};
        vt[5]  = '{1'b0, 1'b0, A_CLKDIV, 32'h1234_5678};
        vt[6]  = '{1'b1, 1'b0, 3'd5,     32'hFFFF_FFFF};
        vt[7]  = '{1'b0, 1'b0, 3'd5,     32'd0};
        vt[8]  = '{1'b0, 1'b0, 3'd6,     32'd0};
        vt[9]  = '{1'b0, 1'b0, 3'd7,     32'd0};
        vt[10] = '{1'b1, 1'b0, A_CTRL,   32'h0000_0005};
        vt[11] = '{1'b0, 1'b0, A_CTRL,   32'h1 | CTRL_IRQ_BIT};
        vt[12] = '{1'b1, 1'b0, A_CTRL,   32'd0};
        vt[13] = '{1'b0, 1'b0, A_RXDATA, 32'd0};
        vt[14] = '{1'b1, 1'b0, A_CLKDIV, 32'd249};

        // reset state
        do_reset(2);
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_clk_div", clk_div, 32'd249);
`ifdef I2C_IRQ_EN
        chk("rst_irq", 32'(irq), 32'd0);
`endif

        // register vector table
        for (int i = 0; i < NV; i++) begin
            core_busy = vt[i].busy;
            if (vt[i].is_wr) begin
                wr(vt[i].addr, vt[i].data);
            end else begin
                rd(vt[i].addr, d);
                chk($sformatf("vec%0d", i), d, vt[i].data);
            end
        end
        core_busy = 1'b0;
        tick(); tick();
        chk("readdata_hold", avs_readdata, 32'd0);

        // command handshake, ready every other cycle
        wr(A_CTRL, 32'h1);
        wr(A_CMD, 32'h1A0);
        wr(A_CMD, 32'h255);
        rd_chk("hs_lvl2", A_STATUS, 32'h0000_0208);
        chk("hs_v0", 32'(cmd_valid), 32'd1);
        chk("hs_d0", {24'd0, cmd_data}, 32'h0000_00A0);
        chk("hs_ss0", {28'd0, cmd_nack, cmd_read, cmd_stop, cmd_start}, 32'h1);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        rd_chk("hs_lvl1", A_STATUS, 32'h0000_0108);
        chk("hs_d1", {24'd0, cmd_data}, 32'h0000_0055);
        chk("hs_ss1", {28'd0, cmd_nack, cmd_read, cmd_stop, cmd_start}, 32'h2);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        rd_chk("hs_lvl0", A_STATUS, 32'h0000_000C);
        chk("hs_v_end", 32'(cmd_valid), 32'd0);

        // command overflow while disabled, then drain in order
        wr(A_CTRL, 32'h0);
        cmd_ready = 1'b1;
        for (int i = 0; i < 9; i++) wr(A_CMD, 32'h10 + 32'(i));
        chk("ovf_hold_valid", 32'(cmd_valid), 32'd0);
        rd_chk("ovf_status", A_STATUS, 32'h0000_082A);
        wr(A_STATUS, 32'h20);
        rd_chk("ovf_w1c", A_STATUS, 32'h0000_080A);
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), {23'd0, cmd_valid, cmd_data}, 32'h110 + 32'(i));
            tick();
        end
        chk("drain_empty", 32'(cmd_valid), 32'd0);
        cmd_ready = 1'b0;
        wr(A_CTRL, 32'h0);

        // RX overflow and ordering
        for (int i = 1; i <= 9; i++) rsp_push(8'(i));
        rd_chk("rx_ovf_status", A_STATUS, 32'h0008_0054);
        for (int i = 1; i <= 8; i++) rd_chk($sformatf("rx_rd%0d", i), A_RXDATA, 32'h100 + 32'(i));
        rd_chk("rx_rd_empty", A_RXDATA, 32'd0);
        wr(A_STATUS, 32'h40);
        rd_chk("rx_w1c", A_STATUS, 32'h0000_000C);

        // pop on empty with same-cycle push; push+pop on non-empty
        avs_address = A_RXDATA; avs_read = 1'b1;
        rsp_valid = 1'b1; rsp_is_read = 1'b1; rsp_data = 8'h77;
        tick();
        avs_read = 1'b0; rsp_valid = 1'b0; rsp_is_read = 1'b0;
        chk("pop_empty_push", avs_readdata, 32'd0);
        rd_chk("pushed_kept", A_RXDATA, 32'h0000_0177);
        rsp_push(8'hAA);
        avs_address = A_RXDATA; avs_read = 1'b1;
        rsp_valid = 1'b1; rsp_is_read = 1'b1; rsp_data = 8'hBB;
        tick();
        avs_read = 1'b0; rsp_valid = 1'b0; rsp_is_read = 1'b0;
        chk("pushpop_data", avs_readdata, 32'h0000_01AA);
        rd_chk("pushpop_lvl", A_STATUS, 32'h0001_0004);
        rd_chk("pushpop_next", A_RXDATA, 32'h0000_01BB);

        // NACK, W1C versus set, flush
        wr(A_CMD, 32'h033);
        wr(A_CMD, 32'h044);
        rsp_push(8'h5A);
        rsp_valid = 1'b1; rsp_nack = 1'b1; tick(); rsp_valid = 1'b0; rsp_nack = 1'b0;
        rd_chk("nack_status", A_STATUS, 32'h0001_0280);
        rsp_valid = 1'b1; rsp_nack = 1'b1;
        wr(A_STATUS, 32'h80);
        rsp_valid = 1'b0; rsp_nack = 1'b0;
        rd_chk("w1c_vs_set", A_STATUS, 32'h0001_0280);
        wr(A_CTRL, 32'h3);
        rd_chk("flush_status", A_STATUS, 32'h0000_008C);
        rd_chk("flush_selfclr", A_CTRL, 32'h0000_0001);
        chk("flush_valid", 32'(cmd_valid), 32'd0);
        rsp_valid = 1'b1; rsp_is_read = 1'b1; rsp_data = 8'hCC;
        wr(A_CTRL, 32'h2);
        rsp_valid = 1'b0; rsp_is_read = 1'b0;
        rd_chk("flush_wins", A_STATUS, 32'h0000_008C);
        wr(A_STATUS, 32'h80);
        rd_chk("nack_clr", A_STATUS, 32'h0000_000C);

        // reset in the middle of operation
        wr(A_CLKDIV, 32'h0000_ABCD);
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 3; i++) wr(A_CMD, 32'h0A0 + 32'(i));
        chk("mid_valid_pre", 32'(cmd_valid), 32'd1);
        do_reset(1);
        chk("mid_valid", 32'(cmd_valid), 32'd0);
        chk("mid_clk_div", clk_div, 32'd249);
        rd_chk("mid_status", A_STATUS, 32'h0000_000C);
        rd_chk("mid_ctrl", A_CTRL, 32'd0);

`ifdef I2C_IRQ_EN
        core_busy = 1'b1;
        wr(A_CMD, 32'h011);
        wr(A_CTRL, 32'h4);
        chk("irq_en_edge", 32'(irq), 32'd0);
        tick();
        chk("irq_quiet", 32'(irq), 32'd0);
        rsp_push(8'h42);
        chk("irq_lag", 32'(irq), 32'd0);
        tick();
        chk("irq_rx", 32'(irq), 32'd1);
        core_busy = 1'b0;
`endif

        // randomized run against the queue model
        do_reset(2);
        model_reset();
        for (int i = 0; i < 800; i++) begin
            int op, a, rdy_bias;
            chk($sformatf("r%0d_valid", i), 32'(cmd_valid), 32'(men && mcq.size() != 0));
            if (men && mcq.size() != 0)
                chk($sformatf("r%0d_head", i), {20'd0, cmd_nack, cmd_read, cmd_stop, cmd_start, cmd_data},
                    {20'd0, mcq[0]});
            chk($sformatf("r%0d_rdata", i), avs_readdata, mrd);
            chk($sformatf("r%0d_clkdiv", i), clk_div, mdiv);
`ifdef I2C_IRQ_EN
            chk($sformatf("r%0d_irq", i), 32'(irq), 32'(mirq));
`endif
            op = $urandom_range(0, 3);
            a  = $urandom_range(0, 9);
            if (a == 8) a = 2;
            if (a == 9) a = 3;
            rdy_bias = ((i / 100) % 2 == 0) ? 1 : 6;
            avs_read      = (op == 1);
            avs_write     = (op >= 2);
            avs_address   = 3'(a);
            avs_writedata = $urandom;
            if (a == 0) begin
                avs_writedata[0] = ($urandom_range(0, 3) != 0);
                avs_writedata[1] = ($urandom_range(0, 15) == 0);
            end
            cmd_ready   = ($urandom_range(0, 7) < rdy_bias);
            rsp_valid   = ($urandom_range(0, 2) == 0);
            rsp_is_read = ($urandom_range(0, 1) == 1);
            rsp_data    = 8'($urandom);
            rsp_nack    = ($urandom_range(0, 3) == 0);
            core_busy   = ($urandom_range(0, 1) == 1);
            model_step();
            tick();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
